// File: rtl/bp_fe_cache_req_arbiter.sv
// Arbitrates the single I$ cache-request port between the demand miss path and the
// next-line prefetcher, holding one registered request until the engine accepts it.
module bp_fe_cache_req_arbiter #(
    parameter int req_width_p          = 64,
    parameter int max_outstanding_p    = 4,
    parameter int pf_max_outstanding_p = 2,
    parameter int starve_limit_p       = 8,
    localparam int cnt_width_lp        = $clog2(max_outstanding_p + 1),
    localparam int starve_width_lp     = $clog2(starve_limit_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [req_width_p-1:0]  demand_req_i,
    input  logic                    demand_v_i,
    output logic                    demand_yumi_o,
    input  logic [req_width_p-1:0]  pf_req_i,
    input  logic                    pf_v_i,
    output logic                    pf_yumi_o,
    output logic [req_width_p-1:0]  cache_req_o,
    output logic                    cache_req_v_o,
    input  logic                    cache_req_yumi_i,
    input  logic                    cache_req_lock_i,
    input  logic                    cache_req_credits_full_i,
    input  logic                    cache_req_done_i,
    output logic                    grant_pf_o,
    output logic [cnt_width_lp-1:0] outstanding_o,
    output logic                    err_o
);

    localparam logic [cnt_width_lp-1:0]    max_out_lp    = cnt_width_lp'(max_outstanding_p);
    localparam logic [cnt_width_lp-1:0]    pf_max_out_lp = cnt_width_lp'(pf_max_outstanding_p);
    localparam logic [cnt_width_lp-1:0]    cnt_one_lp    = cnt_width_lp'(1);
    localparam logic [starve_width_lp-1:0] starve_lim_lp = starve_width_lp'(starve_limit_p);
    localparam logic [starve_width_lp-1:0] starve_one_lp = starve_width_lp'(1);

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_send = 2'd1,
        e_lock = 2'd2
    } state_e;

    state_e                     state_r;
    state_e                     state_n_s;
    logic [req_width_p-1:0]     req_r;
    logic                       v_r;
    logic                       grant_pf_r;
    logic [cnt_width_lp-1:0]    out_r;
    logic [cnt_width_lp-1:0]    out_n_s;
    logic                       err_r;
    logic                       err_n_s;
    logic [starve_width_lp-1:0] starve_r;
    logic [starve_width_lp-1:0] starve_n_s;

    logic cap_ok_s;
    logic pf_elig_s;
    logic starved_s;
    logic pick_pf_s;
    logic pf_yumi_s;
    logic demand_yumi_s;
    logic capture_s;
    logic inc_s;
    logic dec_s;

    // Capture eligibility and priority; reset gating keeps yumi low while reset is held.
    always_comb begin
        cap_ok_s      = reset_n_i
                      & (state_r == e_idle)
                      & ~cache_req_lock_i
                      & ~cache_req_credits_full_i
                      & (out_r < max_out_lp);
        pf_elig_s     = pf_v_i & (out_r < pf_max_out_lp);
        starved_s     = (starve_r == starve_lim_lp);
        pick_pf_s     = pf_elig_s & (starved_s | ~demand_v_i);
        pf_yumi_s     = cap_ok_s & pick_pf_s;
        demand_yumi_s = cap_ok_s & demand_v_i & ~pick_pf_s;
        capture_s     = pf_yumi_s | demand_yumi_s;
    end

    assign demand_yumi_o = demand_yumi_s;
    assign pf_yumi_o     = pf_yumi_s;

    // Next-state logic for the idle/send/lock issue sequence.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            e_idle: begin
                if (capture_s) state_n_s = e_send;
                else           state_n_s = e_idle;
            end
            e_send: begin
                if (cache_req_yumi_i) state_n_s = e_lock;
                else                  state_n_s = e_send;
            end
            e_lock: begin
                if (cache_req_lock_i) state_n_s = e_lock;
                else                  state_n_s = e_idle;
            end
            default: state_n_s = e_idle;
        endcase
    end

    // Starvation counter: counts demand wins over an eligible prefetch, saturating.
    always_comb begin
        starve_n_s = starve_r;
        if (pf_yumi_s) begin
            starve_n_s = '0;
        end else if (demand_yumi_s && pf_elig_s && !starved_s) begin
            starve_n_s = starve_r + starve_one_lp;
        end else begin
            starve_n_s = starve_r;
        end
    end

    // Outstanding fills and sticky underflow error; a done that coincides with an
    // accept cancels it even at zero.
    always_comb begin
        inc_s   = (state_r == e_send) & cache_req_yumi_i;
        dec_s   = cache_req_done_i & ((out_r != '0) | inc_s);
        out_n_s = out_r;
        case ({inc_s, dec_s})
            2'b10: begin
                if (out_r < max_out_lp) out_n_s = out_r + cnt_one_lp;
                else                    out_n_s = out_r;
            end
            2'b01:   out_n_s = out_r - cnt_one_lp;
            default: out_n_s = out_r;
        endcase
        err_n_s = err_r | (cache_req_done_i & (out_r == '0) & ~inc_s);
    end

    // State, counters and error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            v_r      <= 1'b0;
            out_r    <= '0;
            err_r    <= 1'b0;
            starve_r <= '0;
        end else begin
            state_r  <= state_n_s;
            v_r      <= (state_n_s == e_send);
            out_r    <= out_n_s;
            err_r    <= err_n_s;
            starve_r <= starve_n_s;
        end
    end

    // Request register: loads the winner's packet on capture, otherwise holds.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_r      <= '0;
            grant_pf_r <= 1'b0;
        end else if (capture_s) begin
            req_r      <= pf_yumi_s ? pf_req_i : demand_req_i;
            grant_pf_r <= pf_yumi_s;
        end else begin
            req_r      <= req_r;
            grant_pf_r <= grant_pf_r;
        end
    end

    assign cache_req_o   = req_r;
    assign cache_req_v_o = v_r;
    assign grant_pf_o    = grant_pf_r;
    assign outstanding_o = out_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Directed self-checking bench for bp_fe_cache_req_arbiter: inputs change 1 ns after
// the rising edge, outputs are compared 2 ns after it.
module tb_bp_fe_cache_req_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [63:0] demand_req_i;
    logic        demand_v_i;
    logic        demand_yumi_o;
    logic [63:0] pf_req_i;
    logic        pf_v_i;
    logic        pf_yumi_o;
    logic [63:0] cache_req_o;
    logic        cache_req_v_o;
    logic        cache_req_yumi_i;
    logic        cache_req_lock_i;
    logic        cache_req_credits_full_i;
    logic        cache_req_done_i;
    logic        grant_pf_o;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    bp_fe_cache_req_arbiter dut (
        .clk_i                    (clk_i),
        .reset_n_i                (reset_n_i),
        .demand_req_i             (demand_req_i),
        .demand_v_i               (demand_v_i),
        .demand_yumi_o            (demand_yumi_o),
        .pf_req_i                 (pf_req_i),
        .pf_v_i                   (pf_v_i),
        .pf_yumi_o                (pf_yumi_o),
        .cache_req_o              (cache_req_o),
        .cache_req_v_o            (cache_req_v_o),
        .cache_req_yumi_i         (cache_req_yumi_i),
        .cache_req_lock_i         (cache_req_lock_i),
        .cache_req_credits_full_i (cache_req_credits_full_i),
        .cache_req_done_i         (cache_req_done_i),
        .grant_pf_o               (grant_pf_o),
        .outstanding_o            (outstanding_o),
        .err_o                    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic zero_inputs();
        demand_req_i             = 64'h0;
        demand_v_i               = 1'b0;
        pf_req_i                 = 64'h0;
        pf_v_i                   = 1'b0;
        cache_req_yumi_i         = 1'b0;
        cache_req_lock_i         = 1'b0;
        cache_req_credits_full_i = 1'b0;
        cache_req_done_i         = 1'b0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        zero_inputs();
        cyc();
        cyc();
        reset_n_i = 1'b1;
    endtask

    // Runs one demand request through idle -> send -> lock -> idle with no fill completion.
    task automatic push_demand(input logic [63:0] pkt);
        demand_req_i     = pkt;
        demand_v_i       = 1'b1;
        cyc();
        demand_v_i       = 1'b0;
        cache_req_yumi_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        zero_inputs();
        #1;
        n_tests++;
        if ({cache_req_v_o, demand_yumi_o, pf_yumi_o, grant_pf_o, err_o, outstanding_o, cache_req_o} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b dy=%0b py=%0b g=%0b err=%0b out=%0d req=%0h expected all zero",
                     cache_req_v_o, demand_yumi_o, pf_yumi_o, grant_pf_o, err_o, outstanding_o, cache_req_o);
        end
        demand_v_i = 1'b1;
        pf_v_i     = 1'b1;
        cyc();
        n_tests++;
        if ({demand_yumi_o, pf_yumi_o, cache_req_v_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_no_yumi: got dy=%0b py=%0b v=%0b expected 0 0 0", demand_yumi_o, pf_yumi_o, cache_req_v_o);
        end
    endtask

    task automatic test_demand_basic();
        do_reset();
        demand_req_i = 64'hA5;
        demand_v_i   = 1'b1;
        #1;
        n_tests++;
        if ({demand_yumi_o, pf_yumi_o, cache_req_v_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_capture: got dy=%0b py=%0b v=%0b expected 1 0 0", demand_yumi_o, pf_yumi_o, cache_req_v_o);
        end
        cyc();
        demand_v_i   = 1'b0;
        demand_req_i = 64'hFF;
        #1;
        n_tests++;
        if ({cache_req_v_o, grant_pf_o, cache_req_o} !== {1'b1, 1'b0, 64'hA5}) begin
            n_fail++;
            $display("FAIL basic_send: got v=%0b g=%0b req=%0h expected 1 0 a5", cache_req_v_o, grant_pf_o, cache_req_o);
        end
        cyc();
        #1;
        n_tests++;
        if ({cache_req_v_o, cache_req_o} !== {1'b1, 64'hA5}) begin
            n_fail++;
            $display("FAIL basic_hold: got v=%0b req=%0h expected 1 a5", cache_req_v_o, cache_req_o);
        end
        cache_req_yumi_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        #1;
        n_tests++;
        if ({cache_req_v_o, outstanding_o} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL basic_accept: got v=%0b out=%0d expected 0 1", cache_req_v_o, outstanding_o);
        end
        cyc();
    endtask

    task automatic test_starvation();
        logic        exp_pf;
        logic [63:0] exp_pkt;
        do_reset();
        for (int g = 0; g < 18; g++) begin
            exp_pf       = (g == 8) || (g == 17);
            demand_req_i = 64'h100 + 64'(g);
            pf_req_i     = 64'h200 + 64'(g);
            exp_pkt      = exp_pf ? (64'h200 + 64'(g)) : (64'h100 + 64'(g));
            demand_v_i   = 1'b1;
            pf_v_i       = 1'b1;
            #1;
            n_tests++;
            if ({demand_yumi_o, pf_yumi_o} !== {~exp_pf, exp_pf}) begin
                n_fail++;
                $display("FAIL starve_yumi[%0d]: got dy=%0b py=%0b expected %0b %0b", g, demand_yumi_o, pf_yumi_o, ~exp_pf, exp_pf);
            end
            cyc();
            #1;
            n_tests++;
            if ({cache_req_v_o, grant_pf_o, cache_req_o} !== {1'b1, exp_pf, exp_pkt}) begin
                n_fail++;
                $display("FAIL starve_send[%0d]: got v=%0b g=%0b req=%0h expected 1 %0b %0h", g, cache_req_v_o, grant_pf_o, cache_req_o, exp_pf, exp_pkt);
            end
            cache_req_yumi_i = 1'b1;
            cyc();
            cache_req_yumi_i = 1'b0;
            cache_req_done_i = 1'b1;
            cyc();
            cache_req_done_i = 1'b0;
        end
        demand_v_i = 1'b0;
        pf_v_i     = 1'b0;
    endtask

    task automatic test_pf_outstanding();
        do_reset();
        push_demand(64'h1);
        push_demand(64'h2);
        pf_req_i = 64'h77;
        pf_v_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({pf_yumi_o, outstanding_o} !== {1'b0, 3'd2}) begin
                n_fail++;
                $display("FAIL pf_blocked[%0d]: got py=%0b out=%0d expected 0 2", i, pf_yumi_o, outstanding_o);
            end
            cyc();
        end
        cache_req_done_i = 1'b1;
        #1;
        n_tests++;
        if (pf_yumi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pf_done_cycle: got py=%0b expected 0", pf_yumi_o);
        end
        cyc();
        cache_req_done_i = 1'b0;
        #1;
        n_tests++;
        if ({pf_yumi_o, outstanding_o} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL pf_capture: got py=%0b out=%0d expected 1 1", pf_yumi_o, outstanding_o);
        end
        cyc();
        pf_v_i = 1'b0;
        #1;
        n_tests++;
        if ({cache_req_v_o, grant_pf_o, cache_req_o} !== {1'b1, 1'b1, 64'h77}) begin
            n_fail++;
            $display("FAIL pf_send: got v=%0b g=%0b req=%0h expected 1 1 77", cache_req_v_o, grant_pf_o, cache_req_o);
        end
        cache_req_yumi_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_lock();
        do_reset();
        demand_req_i = 64'h11;
        demand_v_i   = 1'b1;
        cyc();
        #1;
        n_tests++;
        if ({demand_yumi_o, cache_req_v_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_send_no_yumi: got dy=%0b v=%0b expected 0 1", demand_yumi_o, cache_req_v_o);
        end
        demand_req_i     = 64'h22;
        cache_req_yumi_i = 1'b1;
        cache_req_lock_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({demand_yumi_o, cache_req_v_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got dy=%0b v=%0b expected 0 0", i, demand_yumi_o, cache_req_v_o);
            end
            cyc();
        end
        cache_req_lock_i = 1'b0;
        #1;
        n_tests++;
        if (demand_yumi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_exit_cycle: got dy=%0b expected 0", demand_yumi_o);
        end
        cyc();
        #1;
        n_tests++;
        if (demand_yumi_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_idle_capture: got dy=%0b expected 1", demand_yumi_o);
        end
        cyc();
        demand_v_i = 1'b0;
        #1;
        n_tests++;
        if ({cache_req_v_o, cache_req_o} !== {1'b1, 64'h22}) begin
            n_fail++;
            $display("FAIL lock_send2: got v=%0b req=%0h expected 1 22", cache_req_v_o, cache_req_o);
        end
        cache_req_yumi_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_credits();
        do_reset();
        cache_req_credits_full_i = 1'b1;
        demand_req_i             = 64'h33;
        demand_v_i               = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({demand_yumi_o, cache_req_v_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL credits_blocked[%0d]: got dy=%0b v=%0b expected 0 0", i, demand_yumi_o, cache_req_v_o);
            end
            cyc();
        end
        cache_req_credits_full_i = 1'b0;
        #1;
        n_tests++;
        if (demand_yumi_o !== 1'b1) begin
            n_fail++;
            $display("FAIL credits_release: got dy=%0b expected 1", demand_yumi_o);
        end
        cyc();
        demand_v_i = 1'b0;
        #1;
        n_tests++;
        if ({cache_req_v_o, cache_req_o} !== {1'b1, 64'h33}) begin
            n_fail++;
            $display("FAIL credits_send: got v=%0b req=%0h expected 1 33", cache_req_v_o, cache_req_o);
        end
        cache_req_yumi_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        cyc();
        push_demand(64'h34);
        push_demand(64'h35);
        #1;
        n_tests++;
        if (outstanding_o !== 3'd3) begin
            n_fail++;
            $display("FAIL count_three: got out=%0d expected 3", outstanding_o);
        end
        demand_req_i = 64'h44;
        demand_v_i   = 1'b1;
        cyc();
        demand_v_i       = 1'b0;
        cache_req_yumi_i = 1'b1;
        cache_req_done_i = 1'b1;
        cyc();
        cache_req_yumi_i = 1'b0;
        cache_req_done_i = 1'b0;
        #1;
        n_tests++;
        if ({outstanding_o, err_o} !== {3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL yumi_done_same: got out=%0d err=%0b expected 3 0", outstanding_o, err_o);
        end
        cyc();
        push_demand(64'h45);
        demand_v_i = 1'b1;
        #1;
        n_tests++;
        if ({outstanding_o, demand_yumi_o} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL max_outstanding: got out=%0d dy=%0b expected 4 0", outstanding_o, demand_yumi_o);
        end
        demand_v_i = 1'b0;
    endtask

    task automatic test_err_and_async_reset();
        do_reset();
        cache_req_done_i = 1'b1;
        cyc();
        cache_req_done_i = 1'b0;
        #1;
        n_tests++;
        if ({err_o, outstanding_o} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL err_set: got err=%0b out=%0d expected 1 0", err_o, outstanding_o);
        end
        cyc();
        cyc();
        #1;
        n_tests++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%0b expected 1", err_o);
        end
        demand_req_i = 64'h55;
        demand_v_i   = 1'b1;
        cyc();
        demand_v_i = 1'b0;
        #1;
        n_tests++;
        if ({cache_req_v_o, cache_req_o} !== {1'b1, 64'h55}) begin
            n_fail++;
            $display("FAIL err_send: got v=%0b req=%0h expected 1 55", cache_req_v_o, cache_req_o);
        end
        reset_n_i = 1'b0;
        #1;
        n_tests++;
        if ({cache_req_v_o, err_o, outstanding_o, cache_req_o} !== 69'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b err=%0b out=%0d req=%0h expected all zero", cache_req_v_o, err_o, outstanding_o, cache_req_o);
        end
        reset_n_i = 1'b1;
        cyc();
        #1;
        n_tests++;
        if (cache_req_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_req: got v=%0b expected 0", cache_req_v_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_demand_basic();
        test_starvation();
        test_pf_outstanding();
        test_lock();
        test_credits();
        test_err_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
